// File: rtl/i_sram_port.sv
// i_sram_port: instruction fetch port bridging the fetch stage to an
// sram-like bus (AXI bridge side). One transaction outstanding at a time.
//
// Optional feature: define I_PORT_MISALIGN_EN to enable misaligned-fetch
// checking (adel_o); otherwise adel_o is tied 0 and pcF is issued as-is.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pcF, inst_enF     fetch address / fetch request from the fetch stage
//   pipe_stall        pipeline frozen elsewhere; fetched word must be held
//   flush             redirect; the in-flight fetch is void
//   instrF            instruction word for the current pcF (0 if none)
//   i_stall           fetch not yet satisfied
//   adel_o            misaligned fetch flag
//   inst_req..wdata   sram-like request to the bridge
//   inst_rdata, inst_addr_ok, inst_data_ok   sram-like response
module i_sram_port #(
  parameter logic [1:0] SIZE = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        inst_enF,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic [31:0] instrF,
  output logic        i_stall,
  output logic        adel_o,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t      state;
  logic        discard;
  logic [31:0] addr_r;
  logic [31:0] buf_r;

  logic misalign;
  logic issue;
  logic data_hit;

`ifdef I_PORT_MISALIGN_EN
  assign misalign = inst_enF & (pcF[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A new request leaves only from IDLE.
  assign issue    = (state == IDLE) & inst_enF & ~flush & ~misalign;
  // Bridge returns a word that still belongs to the current fetch.
  assign data_hit = (state == DATA) & inst_data_ok & ~discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      addr_r  <= '0;
      buf_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            addr_r  <= pcF;
            discard <= 1'b0;
            state   <= inst_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          // Request cannot be withdrawn; a flush only marks the reply void.
          if (flush) discard <= 1'b1;
          if (inst_addr_ok) state <= DATA;
        end
        DATA: begin
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (!discard && !flush && pipe_stall) begin
              buf_r <= inst_rdata;
              state <= HOLD;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (flush) begin
            buf_r <= '0;
            state <= IDLE;
          end else if (!pipe_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational outputs: the request and the data_ok word must reach the
  // bus/pipeline in the same cycle, so nothing here is registered.
  always_comb begin
    inst_req   = 1'b0;
    inst_addr  = '0;
    inst_wr    = 1'b0;
    inst_wdata = '0;
    inst_size  = SIZE;
    instrF     = '0;
    i_stall    = 1'b0;
    adel_o     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          inst_req  = issue;
          inst_addr = issue ? pcF : '0;
          adel_o    = misalign;
          i_stall   = inst_enF & ~misalign;
        end
        ADDR: begin
          inst_req  = 1'b1;
          inst_addr = addr_r;
          i_stall   = inst_enF;
        end
        DATA: begin
          i_stall = inst_enF & ~data_hit;
          if (data_hit && !flush) instrF = inst_rdata;
        end
        HOLD: begin
          i_stall = 1'b0;
          instrF  = flush ? '0 : buf_r;
        end
        default: ;
      endcase
    end
  end

endmodule
